anycore_l15_arbiter: RTL and testbench
======================================

# anycore_l15_arbiter

Request arbiter between the AnyCore instruction/data cache miss interfaces and the L1.5 transducer request port. It buffers one pending request per class (imiss, load, store) and selects one winner at a time. It drives a single registered L1.5 request that is held stable until `l15_ack`. Fixed priority with store anti-starvation is the default; round-robin is selectable at compile time.

## Interface
- `ADDR_W`, default `PHY_ADDR_WIDTH` (40): physical address width.
- `STARVE_LIMIT`, default 4: number of consecutive non-store grants while a store waits before the store is forced to win.
- `CNT_W`, default 3: starvation counter width; must satisfy `2^CNT_W > STARVE_LIMIT`.

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `imiss_val` in 1; `imiss_addr` in ADDR_W; `imiss_rdy` out 1: instruction-miss request channel.
- `load_val` in 1; `load_addr` in ADDR_W; `load_rdy` out 1: load-miss request channel.
- `store_val` in 1; `store_addr` in ADDR_W; `store_data` in 64 (byte-order already L1.5 native); `store_size` in 3; `store_rdy` out 1: store channel.
- `l15_ack` in 1: L1.5 accepted the current request.
- `arb_l15_val` out 1; `arb_l15_rqtype` out 5; `arb_l15_address` out ADDR_W; `arb_l15_data` out 64; `arb_l15_size` out 3: registered request to L1.5.
- `arb_grant_class` out 2: class of the current output request (0 none, 1 imiss, 2 load, 3 store).
- `arb_busy` out 1: any slot full or `arb_l15_val` high.

## Operation
- Each class has one slot with a full bit. `<c>_rdy = !full_c`, combinational from the full bit only. The slot is captured on `<c>_val && <c>_rdy`. `<c>_val` while not ready is ignored; the requester must hold or retry.
- Load enable for the output register: `load_out = (!arb_l15_val || l15_ack) && (any slot full)`. When `load_out` is asserted, the winner's slot moves into the output register and that slot's full bit clears.
- When `(arb_l15_val && l15_ack)` and no slot is full, `arb_l15_val` clears next cycle and `arb_grant_class` returns to 0.
- Output encoding by winner:
  - imiss: rqtype `IMISS_RQ`, size `PCX_SZ_4B`, data 0.
  - load: rqtype `LOAD_RQ`, size `PCX_SZ_16B`, data 0.
  - store: rqtype `STORE_RQ`, size `store_size`, data `store_data`.
- Default arbitration is imiss > load > store.
  - `starve_cnt` increments on each imiss or load grant while the store slot is full, saturating at `STARVE_LIMIT`.
  - When `starve_cnt == STARVE_LIMIT` and the store slot is full, the store wins over all classes.
  - `starve_cnt` clears on a store grant, or whenever the store slot is empty.
- Output fields hold constant while `arb_l15_val && !l15_ack`. `l15_ack` while `arb_l15_val` is low is ignored.
- A slot freed in cycle N may be refilled by a new capture in the same clock edge only if the requester sees `rdy` high. It does not see it, because `rdy` is from registered state; refill therefore occurs at N+1 at the earliest.

## Timing
- Reset values: all full bits 0, so all `*_rdy` are 1. `arb_l15_val` 0; rqtype, address, data, size 0; `arb_grant_class` 0; `arb_busy` 0; `starve_cnt` 0; RR pointer points at imiss.
- Latency: capture at edge E0 → slot full → output register loaded at E1 → `arb_l15_val` high one cycle after capture (2 cycles after the `val` cycle starts).
- Back-to-back: if `l15_ack` and another slot is full, the next request appears the cycle after ack with `arb_l15_val` continuously high.
- Per-class throughput: at most one request every 2 cycles.
- Reset asserted mid-operation: all state clears immediately and asynchronously. Pending and in-flight requests are dropped; requesters re-issue after reset.
- Simultaneous capture into an empty slot and arbitration: the new entry is not eligible until the following cycle.

## Configuration
- `ANYCORE_ARB_RR_EN` defined: round-robin among the three classes.
  - A 2-bit pointer names the highest-priority class and advances to the class after each grant's winner.
  - `starve_cnt` is not implemented and reads as 0.
- `ANYCORE_ARB_RR_EN` undefined: fixed priority plus store starvation promotion, as described in Operation.

## Test plan
- Single load, `load_addr=0x80_0000_0010`: `arb_l15_val` rises 2 cycles later with rqtype `LOAD_RQ` and size `PCX_SZ_16B`. Outputs hold for 5 cycles until ack; `load_rdy` is 1 again after the grant.
- Imiss, load and store captured in the same cycle, ack every cycle: grants are imiss, load, store on consecutive cycles and `arb_grant_class` reads 1, 2, 3. Under RR from reset the order is the same.
- Store pending while imiss and load are refilled continuously, `STARVE_LIMIT=4`: store granted after exactly 4 non-store grants; `starve_cnt` returns to 0.
- Store `data=0x0123456789ABCDEF`, `size=3`: output data and size match exactly; data is 0 on a following imiss.
- Assert `rst` for one cycle while `arb_l15_val=1` with two slots full: all outputs read reset values in the same cycle, and no request appears after release.
- `l15_ack` pulsed while `arb_l15_val=0`: no state change; next request is unaffected.

Source files
------------

// File: rtl/anycore_l15_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : anycore_l15_arbiter
// Brief    : Arbitrates imiss/load/store miss requests onto one registered
//            L1.5 request. Define ANYCORE_ARB_RR_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module anycore_l15_arbiter #(
   parameter int ADDR_W       = 40,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              imiss_val,
   input  logic [ADDR_W-1:0] imiss_addr,
   output logic              imiss_rdy,
   input  logic              load_val,
   input  logic [ADDR_W-1:0] load_addr,
   output logic              load_rdy,
   input  logic              store_val,
   input  logic [ADDR_W-1:0] store_addr,
   input  logic [63:0]       store_data,
   input  logic [2:0]        store_size,
   output logic              store_rdy,
   input  logic              l15_ack,
   output logic              arb_l15_val,
   output logic [4:0]        arb_l15_rqtype,
   output logic [ADDR_W-1:0] arb_l15_address,
   output logic [63:0]       arb_l15_data,
   output logic [2:0]        arb_l15_size,
   output logic [1:0]        arb_grant_class,
   output logic              arb_busy
);

   localparam logic [4:0] c_IMISS_RQ   = 5'b10000;
   localparam logic [4:0] c_LOAD_RQ    = 5'b00000;
   localparam logic [4:0] c_STORE_RQ   = 5'b00001;
   localparam logic [2:0] c_PCX_SZ_4B  = 3'b010;
   localparam logic [2:0] c_PCX_SZ_16B = 3'b111;

   localparam logic [1:0] c_CLS_NONE  = 2'd0;
   localparam logic [1:0] c_CLS_IMISS = 2'd1;
   localparam logic [1:0] c_CLS_LOAD  = 2'd2;
   localparam logic [1:0] c_CLS_STORE = 2'd3;

   logic              r_imiss_full;
   logic              r_load_full;
   logic              r_store_full;
   logic [ADDR_W-1:0] r_imiss_addr;
   logic [ADDR_W-1:0] r_load_addr;
   logic [ADDR_W-1:0] r_store_addr;
   logic [63:0]       r_store_data;
   logic [2:0]        r_store_size;

   logic              w_any_full;
   logic              w_load_out;
   logic [1:0]        w_win;

   assign imiss_rdy  = !r_imiss_full;
   assign load_rdy   = !r_load_full;
   assign store_rdy  = !r_store_full;
   assign w_any_full = r_imiss_full || r_load_full || r_store_full;
   assign w_load_out = (!arb_l15_val || l15_ack) && w_any_full;
   assign arb_busy   = w_any_full || arb_l15_val;

   // Capture and release never collide on one slot: capture needs the slot
   // empty, release needs it full, both judged on registered state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_imiss_full <= 1'b0;
         r_imiss_addr <= '0;
      end else if (imiss_val && !r_imiss_full) begin
         r_imiss_full <= 1'b1;
         r_imiss_addr <= imiss_addr;
      end else if (w_load_out && (w_win == c_CLS_IMISS)) begin
         r_imiss_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_load_full <= 1'b0;
         r_load_addr <= '0;
      end else if (load_val && !r_load_full) begin
         r_load_full <= 1'b1;
         r_load_addr <= load_addr;
      end else if (w_load_out && (w_win == c_CLS_LOAD)) begin
         r_load_full <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_store_full <= 1'b0;
         r_store_addr <= '0;
         r_store_data <= '0;
         r_store_size <= '0;
      end else if (store_val && !r_store_full) begin
         r_store_full <= 1'b1;
         r_store_addr <= store_addr;
         r_store_data <= store_data;
         r_store_size <= store_size;
      end else if (w_load_out && (w_win == c_CLS_STORE)) begin
         r_store_full <= 1'b0;
      end
   end

`ifdef ANYCORE_ARB_RR_EN
   // Pointer values: 0 imiss, 1 load, 2 store; it names the preferred class.
   logic [1:0] r_rr_ptr;

   always_comb begin
      w_win = c_CLS_NONE;
      case (r_rr_ptr)
         2'd1: begin
            if (r_load_full)       w_win = c_CLS_LOAD;
            else if (r_store_full) w_win = c_CLS_STORE;
            else if (r_imiss_full) w_win = c_CLS_IMISS;
         end
         2'd2: begin
            if (r_store_full)      w_win = c_CLS_STORE;
            else if (r_imiss_full) w_win = c_CLS_IMISS;
            else if (r_load_full)  w_win = c_CLS_LOAD;
         end
         default: begin
            if (r_imiss_full)      w_win = c_CLS_IMISS;
            else if (r_load_full)  w_win = c_CLS_LOAD;
            else if (r_store_full) w_win = c_CLS_STORE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rr_ptr <= 2'd0;
      end else if (w_load_out) begin
         case (w_win)
            c_CLS_IMISS: r_rr_ptr <= 2'd1;
            c_CLS_LOAD:  r_rr_ptr <= 2'd2;
            default:     r_rr_ptr <= 2'd0;
         endcase
      end
   end
`else
   localparam logic [CNT_W-1:0] c_STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_starve_cnt;

   always_comb begin
      w_win = c_CLS_NONE;
      if (r_store_full && (r_starve_cnt == c_STARVE_MAX)) w_win = c_CLS_STORE;
      else if (r_imiss_full)                              w_win = c_CLS_IMISS;
      else if (r_load_full)                               w_win = c_CLS_LOAD;
      else if (r_store_full)                              w_win = c_CLS_STORE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_starve_cnt <= '0;
      end else if (!r_store_full) begin
         r_starve_cnt <= '0;
      end else if (w_load_out) begin
         if (w_win == c_CLS_STORE)
            r_starve_cnt <= '0;
         else if (r_starve_cnt != c_STARVE_MAX)
            r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
`endif

   // Output register: reloaded only when empty or being acked, so the
   // fields stay frozen for the whole time a request is waiting for ack.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arb_l15_val     <= 1'b0;
         arb_l15_rqtype  <= '0;
         arb_l15_address <= '0;
         arb_l15_data    <= '0;
         arb_l15_size    <= '0;
         arb_grant_class <= c_CLS_NONE;
      end else if (w_load_out) begin
         arb_l15_val     <= 1'b1;
         arb_grant_class <= w_win;
         case (w_win)
            c_CLS_IMISS: begin
               arb_l15_rqtype  <= c_IMISS_RQ;
               arb_l15_address <= r_imiss_addr;
               arb_l15_data    <= '0;
               arb_l15_size    <= c_PCX_SZ_4B;
            end
            c_CLS_LOAD: begin
               arb_l15_rqtype  <= c_LOAD_RQ;
               arb_l15_address <= r_load_addr;
               arb_l15_data    <= '0;
               arb_l15_size    <= c_PCX_SZ_16B;
            end
            default: begin
               arb_l15_rqtype  <= c_STORE_RQ;
               arb_l15_address <= r_store_addr;
               arb_l15_data    <= r_store_data;
               arb_l15_size    <= r_store_size;
            end
         endcase
      end else if (arb_l15_val && l15_ack) begin
         arb_l15_val     <= 1'b0;
         arb_grant_class <= c_CLS_NONE;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_anycore_l15_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_anycore_l15_arbiter
// Brief    : Scoreboard bench for anycore_l15_arbiter (honours ANYCORE_ARB_RR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_anycore_l15_arbiter;

   localparam int ADDR_W       = 40;
   localparam int STARVE_LIMIT = 4;
   localparam int CNT_W        = 3;

   localparam logic [4:0] IMISS_RQ = 5'b10000;
   localparam logic [4:0] LOAD_RQ  = 5'b00000;
   localparam logic [4:0] STORE_RQ = 5'b00001;
   localparam logic [2:0] SZ_4B    = 3'b010;
   localparam logic [2:0] SZ_16B   = 3'b111;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              imiss_val = 1'b0, load_val = 1'b0, store_val = 1'b0;
   logic [ADDR_W-1:0] imiss_addr = '0, load_addr = '0, store_addr = '0;
   logic [63:0]       store_data = '0;
   logic [2:0]        store_size = '0;
   logic              imiss_rdy, load_rdy, store_rdy;
   logic              l15_ack = 1'b0;
   logic              arb_l15_val;
   logic [4:0]        arb_l15_rqtype;
   logic [ADDR_W-1:0] arb_l15_address;
   logic [63:0]       arb_l15_data;
   logic [2:0]        arb_l15_size;
   logic [1:0]        arb_grant_class;
   logic              arb_busy;

   anycore_l15_arbiter #(
      .ADDR_W(ADDR_W), .STARVE_LIMIT(STARVE_LIMIT), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .imiss_val(imiss_val), .imiss_addr(imiss_addr), .imiss_rdy(imiss_rdy),
      .load_val(load_val), .load_addr(load_addr), .load_rdy(load_rdy),
      .store_val(store_val), .store_addr(store_addr), .store_data(store_data),
      .store_size(store_size), .store_rdy(store_rdy),
      .l15_ack(l15_ack),
      .arb_l15_val(arb_l15_val), .arb_l15_rqtype(arb_l15_rqtype),
      .arb_l15_address(arb_l15_address), .arb_l15_data(arb_l15_data),
      .arb_l15_size(arb_l15_size), .arb_grant_class(arb_grant_class),
      .arb_busy(arb_busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [1:0]        cls;
      logic [4:0]        rq;
      logic [ADDR_W-1:0] addr;
      logic [63:0]       data;
      logic [2:0]        size;
   } req_t;

   req_t exp_q[$];
   int   grant_log[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   // Reference model: one pending request record per class, a single
   // in-flight request, and the priority rules applied at each clock edge.
   req_t m_slot[3];
   bit   m_full[3];
   bit   m_val    = 1'b0;
   int   m_starve = 0;
`ifdef ANYCORE_ARB_RR_EN
   int   m_ptr    = 0;
`endif

   function automatic int pick();
`ifdef ANYCORE_ARB_RR_EN
      for (int k = 0; k < 3; k++)
         if (m_full[(m_ptr + k) % 3]) return (m_ptr + k) % 3;
`else
      if (m_full[2] && m_starve == STARVE_LIMIT) return 2;
      for (int k = 0; k < 3; k++)
         if (m_full[k]) return k;
`endif
      return 0;
   endfunction

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         m_full   = '{1'b0, 1'b0, 1'b0};
         m_val    = 1'b0;
         m_starve = 0;
`ifdef ANYCORE_ARB_RR_EN
         m_ptr    = 0;
`endif
         exp_q.delete();
      end else begin
         bit old_full[3];
         bit lo;
         int w;
         old_full = m_full;
         w  = -1;
         lo = (!m_val || l15_ack) && (old_full[0] || old_full[1] || old_full[2]);
         if (lo) begin
            w = pick();
            exp_q.push_back(m_slot[w]);
            m_full[w] = 1'b0;
            m_val     = 1'b1;
`ifdef ANYCORE_ARB_RR_EN
            m_ptr     = (w + 1) % 3;
`endif
         end else if (m_val && l15_ack) begin
            m_val = 1'b0;
         end
         if (!old_full[2])  m_starve = 0;
         else if (lo)       m_starve = (w == 2) ? 0 : ((m_starve < STARVE_LIMIT) ? m_starve + 1 : m_starve);
         if (imiss_val && !old_full[0]) begin
            m_full[0] = 1'b1;
            m_slot[0] = '{cls: 2'd1, rq: IMISS_RQ, addr: imiss_addr, data: 64'd0, size: SZ_4B};
         end
         if (load_val && !old_full[1]) begin
            m_full[1] = 1'b1;
            m_slot[1] = '{cls: 2'd2, rq: LOAD_RQ, addr: load_addr, data: 64'd0, size: SZ_16B};
         end
         if (store_val && !old_full[2]) begin
            m_full[2] = 1'b1;
            m_slot[2] = '{cls: 2'd3, rq: STORE_RQ, addr: store_addr, data: store_data, size: store_size};
         end
      end
   end

   // Monitor: compares the presented request with the scoreboard head every
   // cycle and retires it when the ack handshake completes.
   initial forever begin
      req_t e;
      @(negedge clk);
      if (!rst) begin
         check("val", 128'(arb_l15_val), 128'(m_val));
         check("rdy", 128'({imiss_rdy, load_rdy, store_rdy}), 128'({!m_full[0], !m_full[1], !m_full[2]}));
         check("busy", 128'(arb_busy), 128'(m_full[0] || m_full[1] || m_full[2] || m_val));
         if (arb_l15_val) begin
            if (exp_q.size() == 0) begin
               check("unexpected_req", 128'(arb_grant_class), 128'(0));
            end else begin
               e = exp_q[0];
               check("class",  128'(arb_grant_class), 128'(e.cls));
               check("rqtype", 128'(arb_l15_rqtype),  128'(e.rq));
               check("addr",   128'(arb_l15_address), 128'(e.addr));
               check("data",   128'(arb_l15_data),    128'(e.data));
               check("size",   128'(arb_l15_size),    128'(e.size));
               if (l15_ack) begin
                  grant_log.push_back(int'(e.cls));
                  void'(exp_q.pop_front());
               end
            end
         end else begin
            check("class_idle", 128'(arb_grant_class), 128'(0));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      imiss_val = 1'b0; load_val = 1'b0; store_val = 1'b0; l15_ack = 1'b0;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   function automatic int log_at(input int i);
      return (i < grant_log.size()) ? grant_log[i] : -1;
   endfunction

   initial begin
      int pos;
      int n;
      repeat (2) tick();
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check("rst_rqtype", 128'(arb_l15_rqtype), 128'(0));
      check("rst_addr",   128'(arb_l15_address), 128'(0));
      check("rst_data",   128'(arb_l15_data), 128'(0));
      check("rst_size",   128'(arb_l15_size), 128'(0));
      check("rst_rdy",    128'({imiss_rdy, load_rdy, store_rdy}), 128'(3'b111));
      tick();

      // Single load held 5 cycles before ack
      load_val = 1'b1; load_addr = 40'h80_0000_0010;
      tick();
      load_val = 1'b0;
      tick();
      @(negedge clk);
      check("load_val_latency", 128'(arb_l15_val), 128'(1));
      check("load_rqtype", 128'(arb_l15_rqtype), 128'(LOAD_RQ));
      check("load_size",   128'(arb_l15_size), 128'(SZ_16B));
      check("load_rdy_after_grant", 128'(load_rdy), 128'(1));
      repeat (4) tick();
      l15_ack = 1'b1;
      tick();
      l15_ack = 1'b0;
      repeat (2) tick();

      // Ack while idle is ignored
      l15_ack = 1'b1;
      tick();
      l15_ack = 1'b0;
      imiss_val = 1'b1; imiss_addr = 40'h12_3456_7000;
      tick();
      imiss_val = 1'b0;
      repeat (3) tick();
      l15_ack = 1'b1;
      tick();
      l15_ack = 1'b0;
      tick();

      // All three classes captured together, ack every cycle
      do_reset();
      grant_log.delete();
      l15_ack = 1'b1;
      imiss_val = 1'b1; load_val = 1'b1; store_val = 1'b1;
      imiss_addr = 40'h00_0000_1000; load_addr = 40'h00_0000_2000; store_addr = 40'h00_0000_3000;
      store_data = 64'hDEAD_BEEF_0000_0001; store_size = 3'd3;
      tick();
      clear_inputs();
      l15_ack = 1'b1;
      repeat (6) tick();
      check("order_n",  128'(grant_log.size()), 128'(3));
      check("order_0",  128'(log_at(0)), 128'(1));
      check("order_1",  128'(log_at(1)), 128'(2));
      check("order_2",  128'(log_at(2)), 128'(3));

      // Store data path, then an imiss that must carry zero data
      store_val = 1'b1; store_addr = 40'hAB_CDEF_0008;
      store_data = 64'h0123_4567_89AB_CDEF; store_size = 3'd3;
      tick();
      store_val = 1'b0; imiss_val = 1'b1; imiss_addr = 40'h00_0000_4000;
      tick();
      imiss_val = 1'b0;
      repeat (4) tick();

      // Store starvation with imiss and load refilled continuously
      do_reset();
      grant_log.delete();
      l15_ack = 1'b1;
      imiss_val = 1'b1; load_val = 1'b1; store_val = 1'b1;
      store_data = 64'h5555_AAAA_5555_AAAA; store_size = 3'd2;
      tick();
      store_val = 1'b0;
      repeat (8) tick();
      imiss_val = 1'b0; load_val = 1'b0;
      repeat (6) tick();
      pos = -1;
      foreach (grant_log[i]) if (pos < 0 && grant_log[i] == 3) pos = i;
`ifdef ANYCORE_ARB_RR_EN
      check("grants_before_store", 128'(pos), 128'(2));
`else
      check("grants_before_store", 128'(pos), 128'(STARVE_LIMIT));
      check("starve_cnt_cleared", 128'(dut.r_starve_cnt), 128'(0));
`endif

      // Reset while a request is in flight and two slots are full
      clear_inputs();
      imiss_val = 1'b1; load_val = 1'b1; store_val = 1'b1;
      tick();
      clear_inputs();
      tick();
      rst = 1'b1;
      #1;
      check("amid_val",    128'(arb_l15_val), 128'(0));
      check("amid_class",  128'(arb_grant_class), 128'(0));
      check("amid_fields", 128'({arb_l15_rqtype, arb_l15_address, arb_l15_data, arb_l15_size}), 128'(0));
      check("amid_rdy",    128'({imiss_rdy, load_rdy, store_rdy}), 128'(3'b111));
      check("amid_busy",   128'(arb_busy), 128'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      l15_ack = 1'b1;
      repeat (4) tick();
      check("after_rst_idle", 128'(arb_l15_val), 128'(0));

      // Randomised traffic
      for (int c = 0; c < 400; c++) begin
         imiss_val  = 1'($urandom_range(0, 1));
         load_val   = 1'($urandom_range(0, 1));
         store_val  = 1'($urandom_range(0, 1));
         imiss_addr = ADDR_W'({$urandom(), $urandom()});
         load_addr  = ADDR_W'({$urandom(), $urandom()});
         store_addr = ADDR_W'({$urandom(), $urandom()});
         store_data = {$urandom(), $urandom()};
         store_size = 3'($urandom_range(0, 7));
         l15_ack    = ($urandom_range(0, 2) != 0);
         tick();
      end

      // Drain
      clear_inputs();
      l15_ack = 1'b1;
      n = 0;
      @(negedge clk);
      while (arb_busy && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain_timeout", 128'(arb_busy), 128'(0));
      check("scoreboard_empty", 128'(exp_q.size()), 128'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
